// File: rtl/i2c_slave_with_8bits_io_v2.sv
// I2C slave with one 8-bit output register: master writes load IOout, master reads return it.
// SCL/SDA are oversampled on clk; the slave only ever pulls SDA low.
`timescale 1ns/1ps
module i2c_slave_with_8bits_io_v2 (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [6:0] ADR,
  output logic [7:0] IOout
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE
  } state_t;

  state_t      state, next_state;
  logic        scl_s1, scl_s2, scl_d;
  logic        sda_s1, sda_s2, sda_d;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;
  logic        rd_nack;
  logic        sda_low;
  logic        scl_rise, scl_fall, start_cond, stop_cond;

  // Synchronizers reset to the idle-bus level so reset release never looks like a START.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scl_s1 <= 1'b1; scl_s2 <= 1'b1; scl_d <= 1'b1;
      sda_s1 <= 1'b1; sda_s2 <= 1'b1; sda_d <= 1'b1;
    end else begin
      scl_s1 <= SCL;    scl_s2 <= scl_s1; scl_d <= scl_s2;
      sda_s1 <= SDA;    sda_s2 <= sda_s1; sda_d <= sda_s2;
    end
  end

  assign scl_rise   = scl_s2 & ~scl_d;
  assign scl_fall   = ~scl_s2 & scl_d;
  assign start_cond = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_cond  = scl_s2 & scl_d & ~sda_d & sda_s2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Every bit/ACK phase ends on an SCL falling edge, so SDA only moves while SCL is low.
  always_comb begin
    next_state = state;
    if (stop_cond) begin
      next_state = IDLE;
    end else if (start_cond) begin
      next_state = ADDR;
    end else begin
      case (state)
        ADDR:     if (scl_fall && bit_cnt == 4'd8)
                    next_state = (shift[7:1] == ADR) ? ADDR_ACK : IGNORE;
        ADDR_ACK: if (scl_fall) next_state = shift[0] ? RD_DATA : WR_DATA;
        WR_DATA:  if (scl_fall && bit_cnt == 4'd8) next_state = WR_ACK;
        WR_ACK:   if (scl_fall) next_state = WR_DATA;
        RD_DATA:  if (scl_fall && bit_cnt == 4'd8) next_state = RD_ACK;
        RD_ACK:   if (scl_fall) next_state = rd_nack ? IGNORE : RD_DATA;
        default:  next_state = state;
      endcase
    end
  end

  always_comb begin
    sda_low = 1'b0;
    case (state)
      ADDR_ACK, WR_ACK: sda_low = 1'b1;
      RD_DATA:          sda_low = ~shift[7];
      default:          sda_low = 1'b0;
    endcase
  end

  assign SDA = sda_low ? 1'b0 : 1'bz;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift   <= 8'h00;
      bit_cnt <= 4'd0;
      rd_nack <= 1'b0;
      IOout   <= 8'h00;
    end else if (start_cond || stop_cond) begin
      bit_cnt <= 4'd0;
    end else begin
      case (state)
        ADDR, WR_DATA: begin
          if (scl_rise) begin
            shift   <= {shift[6:0], sda_s2};
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt <= 4'd0;
            if (state == WR_DATA) IOout <= shift;
          end
        end
        ADDR_ACK: if (scl_fall && shift[0]) shift <= IOout;
        RD_DATA: begin
          if (scl_rise) begin
            bit_cnt <= bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) bit_cnt <= 4'd0;
            else                 shift   <= {shift[6:0], 1'b0};
          end
        end
        RD_ACK: begin
          if (scl_rise)                  rd_nack <= sda_s2;
          else if (scl_fall && !rd_nack) shift   <= IOout;
        end
        default: bit_cnt <= 4'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_slave_with_8bits_io_v2.sv
// Bench for i2c_slave_with_8bits_io_v2: a bit-level I2C master with a scoreboard on
// every bit the slave puts on SDA (ACKs and read bytes) and a model of IOout.
`timescale 1ns/1ps
module tb_i2c_slave_with_8bits_io_v2;

  localparam int Q = 100;  // quarter of an SCL period, 10 clk cycles

  logic       clk;
  logic       reset;
  logic       scl;
  logic       m_low;
  logic [6:0] adr;
  logic [7:0] io_out;
  wire        sda;

  logic [7:0] exp_q[$];
  logic [7:0] exp_io;
  int         n_checks;
  int         n_fail;
  int         low_cnt;
  int         c0;
  logic       slave_low;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);
  assign slave_low = (sda == 1'b0) && !m_low;

  i2c_slave_with_8bits_io_v2 dut (
    .clk   (clk),
    .reset (reset),
    .SCL   (scl),
    .SDA   (sda),
    .ADR   (adr),
    .IOout (io_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (slave_low) low_cnt <= low_cnt + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic bus_start();
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b1; #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic bus_stop();
    m_low = 1'b1; #Q;
    scl = 1'b1;   #Q;
    m_low = 1'b0; #(2*Q);
  endtask

  task automatic put_bit(input logic b);
    m_low = !b; #Q;
    scl = 1'b1; #(2*Q);
    scl = 1'b0; #Q;
  endtask

  task automatic ack_slot(input logic [7:0] exp_ack, input string tag);
    exp_q.push_back(exp_ack);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    check_eq({tag, "_ack"}, {7'd0, sda}, exp_q.pop_front());
    check_eq({tag, "_io"}, io_out, exp_io);
    #Q;
    scl = 1'b0;   #Q;
  endtask

  task automatic write_byte(input logic [7:0] d, input logic [7:0] exp_ack,
                            input logic upd, input string tag);
    for (int i = 7; i >= 1; i--) put_bit(d[i]);
    m_low = !d[0]; #Q;
    scl = 1'b1;    #Q;
    check_eq({tag, "_hold"}, io_out, exp_io);
    #Q;
    scl = 1'b0;    #Q;
    if (upd) exp_io = d;
    ack_slot(exp_ack, tag);
  endtask

  task automatic read_byte(input logic master_ack, input string tag);
    logic [7:0] got;
    got = 8'h00;
    exp_q.push_back(exp_io);
    for (int i = 7; i >= 0; i--) begin
      m_low = 1'b0; #Q;
      scl = 1'b1;   #Q;
      got[i] = sda;
      #Q;
      scl = 1'b0;   #Q;
    end
    check_eq(tag, got, exp_q.pop_front());
    put_bit(!master_ack);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    low_cnt  = 0;
    exp_io   = 8'h00;
    reset    = 1'b1;
    scl      = 1'b1;
    m_low    = 1'b0;
    adr      = 7'h10;

    // reset with idle bus
    #(Q);
    check_eq("rst_io", io_out, 8'h00);
    check_eq("rst_sda", {7'd0, slave_low}, 8'h00);
    reset = 1'b0;
    #(2*Q);
    check_eq("post_rst_io", io_out, 8'h00);
    check_eq("post_rst_sda", {7'd0, slave_low}, 8'h00);

    // write hit
    bus_start();
    write_byte(8'h20, 8'h00, 1'b0, "w_addr");
    write_byte(8'h8E, 8'h00, 1'b1, "w_data");
    check_eq("w_ack_rel", {7'd0, slave_low}, 8'h00);
    bus_stop();
    check_eq("w_io", io_out, 8'h8E);

    // address miss
    c0 = low_cnt;
    bus_start();
    write_byte(8'h2E, 8'h01, 1'b0, "m_addr");
    write_byte(8'h22, 8'h01, 1'b0, "m_data");
    bus_stop();
    check_eq("m_nodrive", 8'(low_cnt - c0), 8'h00);
    check_eq("m_io", io_out, 8'h8E);

    // multi-byte write, then repeated START and read
    bus_start();
    write_byte(8'h20, 8'h00, 1'b0, "mb_addr");
    write_byte(8'h55, 8'h00, 1'b1, "mb_d0");
    write_byte(8'hAA, 8'h00, 1'b1, "mb_d1");
    bus_start();
    write_byte(8'h21, 8'h00, 1'b0, "rd_addr");
    read_byte(1'b1, "rd_b0");
    read_byte(1'b0, "rd_b1");
    check_eq("rd_nack_rel", {7'd0, slave_low}, 8'h00);
    bus_stop();
    check_eq("rd_stop_rel", {7'd0, slave_low}, 8'h00);
    check_eq("rd_io", io_out, 8'hAA);

    // abort after four data bits
    bus_start();
    write_byte(8'h20, 8'h00, 1'b0, "ab_addr");
    put_bit(1'b0); put_bit(1'b0); put_bit(1'b1); put_bit(1'b1);
    bus_stop();
    check_eq("ab_io", io_out, 8'hAA);
    check_eq("ab_rel", {7'd0, slave_low}, 8'h00);
    bus_start();
    write_byte(8'h20, 8'h00, 1'b0, "ab2_addr");
    write_byte(8'h3C, 8'h00, 1'b1, "ab2_data");
    bus_stop();
    check_eq("ab2_io", io_out, 8'h3C);

    // reset while the slave drives the address ACK
    bus_start();
    for (int i = 7; i >= 0; i--) put_bit(i == 5);
    m_low = 1'b0; #Q;
    scl = 1'b1;   #Q;
    check_eq("ra_drive", {7'd0, slave_low}, 8'h01);
    reset = 1'b1;
    #2;
    check_eq("ra_rel", {7'd0, slave_low}, 8'h00);
    check_eq("ra_io", io_out, 8'h00);
    exp_io = 8'h00;
    #Q;
    scl = 1'b0; #Q;
    reset = 1'b0; #Q;
    bus_stop();
    check_eq("ra_post_io", io_out, 8'h00);

    // slave still functional after the reset
    bus_start();
    write_byte(8'h20, 8'h00, 1'b0, "fin_addr");
    write_byte(8'h5A, 8'h00, 1'b1, "fin_data");
    bus_stop();
    check_eq("fin_io", io_out, 8'h5A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_slave_with_8bits_io_v2.md
# i2c_slave_with_8bits_io_v2

I2C slave peripheral with a single 8-bit parallel output register. The block sits between an external I2C bus (open-drain SDA, master-driven SCL) and on-chip logic. A master write addressed to the block's 7-bit address loads the register and drives `IOout`; a master read returns the current register value. All logic runs on one system clock; SCL and SDA are oversampled, not used as clocks.

## Interface
- No parameters.
- `clk` input 1 — system clock; sole clock of the block.
- `reset` input 1 — asynchronous, active-high reset.
- `SCL` input 1 — I2C clock from the master; slave never stretches.
- `SDA` inout 1 — I2C data, open-drain: drives `0` or `z`, never `1`; externally pulled up.
- `ADR` input 7 — slave address, static during operation.
- `IOout` output 8 — parallel output register; reset value `8'h00`.

## Operation
- SCL and SDA pass through 2-FF synchronizers; edges are detected on the synchronized copies.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high. Both are recognized in every state.
- States:
  - `IDLE` — SDA released; START -> `ADDR`.
  - `ADDR` — shift 8 bits MSB first on SCL rising edges: 7 address bits, then R/W. After the 8th bit: if address == `ADR` -> `ADDR_ACK`, else -> `IGNORE`.
  - `ADDR_ACK` — drive SDA low for the 9th clock. R/W = 0 -> `WR_DATA`; R/W = 1 -> load shifter from `IOout`, then -> `RD_DATA`.
  - `WR_DATA` — shift 8 bits MSB first, then -> `WR_ACK`.
  - `WR_ACK` — `IOout` <= received byte; drive SDA low for the 9th clock; -> `WR_DATA`. Multiple bytes are allowed; each overwrites `IOout`.
  - `RD_DATA` — present one bit per clock, MSB first: SDA low for a 0 bit, released for a 1 bit; -> `RD_ACK`.
  - `RD_ACK` — release SDA and sample the master's ACK on the SCL rising edge. ACK (low): reload from `IOout` -> `RD_DATA`. NACK (high): -> `IGNORE`.
  - `IGNORE` — SDA released; waits for START or STOP.
- START in any state -> `ADDR` (repeated start). STOP in any state -> `IDLE`. Both release SDA immediately; `IOout` keeps its value.
- Address 0 (general call) has no special handling: it is compared against `ADR` like any other address.
- Reset (any time, including mid-byte): state `IDLE`, SDA released, `IOout` = `8'h00`, shifters and bit counter cleared.

## Timing
- `clk` frequency is at least 8× the frequency of the fastest SCL/SDA phase change. Example: 50 ns bus phases need `clk` ≥ 160 MHz; 100 MHz+ is recommended for 400 kHz buses.
- SDA is sampled on the synchronized SCL rising edge.
- Slave-driven SDA changes only on the synchronized SCL falling edge, 2–3 `clk` cycles after the pin edge. This keeps the slave from creating a false START/STOP.
- ACK: SDA is driven low from the falling edge ending bit 8 until the falling edge ending bit 9.
- `IOout` updates on the SCL falling edge ending data bit 8 (the start of ACK), within 3 `clk` cycles of that pin edge. It is stable at all other times.
- A received byte that is interrupted by START, STOP or reset is discarded; `IOout` is unchanged (or cleared, on reset).

## Test plan
- Reset: assert `reset` with the bus idle -> `IOout` = `00`, SDA = `z`; deassert -> no change.
- Write hit: `ADR` = `10`, START, `0x20` (addr `10`, W), `8E`, STOP -> ACK low on both 9th clocks; `IOout` = `8E` from the data ACK onward.
- Address miss: after the write hit, START, addr `17` W, data `22`, STOP -> SDA never driven low; `IOout` stays `8E`.
- Multi-byte plus read: write `55`, `AA` in one transfer -> `IOout` = `AA`. Then repeated START, addr `10` R -> slave returns `AA`; master ACK -> `AA` again; master NACK, STOP -> SDA released, state `IDLE`.
- Abort: START, addr `10` W, 4 data bits, STOP -> `IOout` unchanged, SDA released. The next full write of `3C` works.
- Reset mid-ACK: assert `reset` while the slave drives the ACK -> SDA released immediately, `IOout` = `00`.
